// File: rtl/fd_queue_if.sv
// Fetch->Decode instruction-buffer bus: Fetch-side inputs and Decode-side outputs.
// The slave modport is the queue itself; master is the pipeline/bench side.
interface fd_queue_if #(
  parameter int AW = 1
);
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic [31:0] pcplus4_f;
  logic        valid_f;
  logic        stall_d;
  logic        flush;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pcplus4_d;
  logic        valid_d;
  logic        stop_f;
  logic [AW:0] count;

  modport slave (
    input  instr_f, pc_f, pcplus4_f, valid_f, stall_d, flush,
    output instr_d, pc_d, pcplus4_d, valid_d, stop_f, count
  );

  modport master (
    output instr_f, pc_f, pcplus4_f, valid_f, stall_d, flush,
    input  instr_d, pc_d, pcplus4_d, valid_d, stop_f, count
  );
endinterface

// File: rtl/fd_queue.sv
// fd_queue: circular instruction FIFO between Fetch and Decode with flush and backpressure.
// Optional macro FD_BYPASS_EN: an empty queue passes Fetch's instruction straight to Decode.
module fd_queue #(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input logic       clk,
  input logic       reset,
  fd_queue_if.slave bus
);
  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  logic [31:0]   instrMem_q   [DEPTH];
  logic [31:0]   pcMem_q      [DEPTH];
  logic [31:0]   pcplus4Mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [AW:0]   count_q, count_d;
  logic          empty, full, bypass, pop, push;

  assign empty = (count_q == '0);
  assign full  = (count_q == FullCount);

`ifdef FD_BYPASS_EN
  assign bypass = empty && bus.valid_f && !bus.stall_d && !bus.flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed instruction is consumed directly, so it is neither pushed nor popped.
  assign pop  = !empty && !bus.stall_d && !bus.flush;
  assign push = bus.valid_f && !bus.flush && (!full || pop) && !bypass;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (bus.flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + 1'b1;
      if (pop)  rdPtr_d = rdPtr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        instrMem_q[i]   <= '0;
        pcMem_q[i]      <= '0;
        pcplus4Mem_q[i] <= '0;
      end
    end else if (push) begin
      instrMem_q[wrPtr_q]   <= bus.instr_f;
      pcMem_q[wrPtr_q]      <= bus.pc_f;
      pcplus4Mem_q[wrPtr_q] <= bus.pcplus4_f;
    end
  end

  // Empty queue presents an all-zero nop bubble unless the bypass path is active.
  always_comb begin
    bus.instr_d   = '0;
    bus.pc_d      = '0;
    bus.pcplus4_d = '0;
    bus.valid_d   = !empty || bypass;
    if (!empty) begin
      bus.instr_d   = instrMem_q[rdPtr_q];
      bus.pc_d      = pcMem_q[rdPtr_q];
      bus.pcplus4_d = pcplus4Mem_q[rdPtr_q];
    end else if (bypass) begin
      bus.instr_d   = bus.instr_f;
      bus.pc_d      = bus.pc_f;
      bus.pcplus4_d = bus.pcplus4_f;
    end
  end

  assign bus.stop_f = full && !pop;
  assign bus.count  = count_q;

endmodule

// File: tb/tb_fd_queue.sv
// Testbench for fd_queue: scoreboard of expected PCs, one task per scenario.
// Builds with or without FD_BYPASS_EN; the reference model follows the same macro.
module tb_fd_queue;
  localparam int DEPTH = 2;
  localparam int AW    = 1;

  logic clk = 1'b0;
  logic reset;
  int   assertCount = 0;
  int   failCount   = 0;
  logic [31:0] sb[$];

  fd_queue_if #(.AW(AW)) bus ();

  fd_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instrOf(input logic [31:0] pc);
    return {pc[15:0], 16'h2021} ^ 32'h8c000000;
  endfunction

  function automatic logic modelBypass();
`ifdef FD_BYPASS_EN
    return (sb.size() == 0) && bus.valid_f && !bus.stall_d && !bus.flush;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic modelPop();
    return (sb.size() > 0) && !bus.stall_d && !bus.flush;
  endfunction

  function automatic logic expValid();
    return (sb.size() > 0) || modelBypass();
  endfunction

  function automatic logic [31:0] expPc();
    if (sb.size() > 0) return sb[0];
    if (modelBypass()) return bus.pc_f;
    return 32'h0;
  endfunction

  function automatic logic [31:0] expInstr();
    if (!expValid()) return 32'h0;
    return instrOf(expPc());
  endfunction

  function automatic logic [AW:0] expCount();
    return (AW+1)'(sb.size());
  endfunction

  function automatic logic expStop();
    return (sb.size() == DEPTH) && !modelPop();
  endfunction

  task automatic setIn(input logic v, input logic [31:0] pc, input logic st, input logic fl);
    bus.valid_f   = v;
    bus.pc_f      = pc;
    bus.instr_f   = instrOf(pc);
    bus.pcplus4_f = pc + 32'd4;
    bus.stall_d   = st;
    bus.flush     = fl;
    #2;
  endtask

  // Advances one clock and updates the scoreboard with what the queue should accept.
  task automatic clockEdge(output logic took);
    logic pop, push, byp, rst;
    byp  = modelBypass();
    pop  = modelPop();
    push = bus.valid_f && !bus.flush && ((sb.size() < DEPTH) || pop) && !byp;
    rst  = !reset;
    took = (push || byp) && !rst;
    @(posedge clk);
    #1;
    if (rst || bus.flush) sb.delete();
    else begin
      if (pop) void'(sb.pop_front());
      if (push) sb.push_back(bus.pc_f);
    end
  endtask

  task automatic test_reset();
    logic took;
    reset = 1'b0;
    bus.valid_f = 1'b1; bus.instr_f = 32'h3c010001; bus.pc_f = 32'h0;
    bus.pcplus4_f = 32'h4; bus.stall_d = 1'b0; bus.flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      clockEdge(took);
      assertCount++;
      if (bus.count !== '0 || bus.valid_d !== 1'b0 || bus.instr_d !== 32'h0 || bus.stop_f !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL reset_state cycle %0d got count=%0d valid=%b instr=%h stop=%b want 0/0/0/0",
                 i, bus.count, bus.valid_d, bus.instr_d, bus.stop_f);
      end
    end
    reset = 1'b1;
    setIn(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_streaming();
    logic took;
    logic [31:0] pcs [3] = '{32'h3000, 32'h3004, 32'h3008};
    for (int i = 0; i < 4; i++) begin
      if (i < 3) setIn(1'b1, pcs[i], 1'b0, 1'b0);
      else       setIn(1'b0, 32'h0, 1'b0, 1'b0);
      assertCount++;
      if (bus.valid_d !== expValid() || bus.pc_d !== expPc()) begin
        failCount++;
        $display("[TB] FAIL stream_head cycle %0d got valid=%b pc=%h want valid=%b pc=%h",
                 i, bus.valid_d, bus.pc_d, expValid(), expPc());
      end
      assertCount++;
      if (bus.count !== expCount()) begin
        failCount++;
        $display("[TB] FAIL stream_count cycle %0d got %0d want %0d", i, bus.count, expCount());
      end
      clockEdge(took);
    end
  endtask

  task automatic test_backpressure();
    logic took;
    setIn(1'b1, 32'h3000, 1'b1, 1'b0); clockEdge(took);
    setIn(1'b1, 32'h3004, 1'b1, 1'b0); clockEdge(took);
    setIn(1'b1, 32'h3008, 1'b1, 1'b0);
    assertCount++;
    if (bus.count !== 2'd2 || bus.stop_f !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL fill_full got count=%0d stop=%b want 2/1", bus.count, bus.stop_f);
    end
    clockEdge(took);
    assertCount++;
    if (took !== 1'b0 || bus.stop_f !== 1'b1 || bus.pc_d !== 32'h3000) begin
      failCount++;
      $display("[TB] FAIL fill_hold got stop=%b pc=%h want 1 3000", bus.stop_f, bus.pc_d);
    end
    setIn(1'b1, 32'h3008, 1'b0, 1'b0);
    assertCount++;
    if (bus.stop_f !== expStop() || bus.pc_d !== expPc() || bus.instr_d !== expInstr()) begin
      failCount++;
      $display("[TB] FAIL fill_release got stop=%b pc=%h instr=%h want %b %h %h",
               bus.stop_f, bus.pc_d, bus.instr_d, expStop(), expPc(), expInstr());
    end
    clockEdge(took);
    for (int i = 0; i < DEPTH + 2 && sb.size() > 0; i++) begin
      setIn(1'b0, 32'h0, 1'b0, 1'b0);
      assertCount++;
      if (bus.valid_d !== 1'b1 || bus.pc_d !== sb[0] || bus.pcplus4_d !== sb[0] + 32'd4) begin
        failCount++;
        $display("[TB] FAIL fill_order got valid=%b pc=%h pc4=%h want 1 %h %h",
                 bus.valid_d, bus.pc_d, bus.pcplus4_d, sb[0], sb[0] + 32'd4);
      end
      clockEdge(took);
    end
    assertCount++;
    if (bus.valid_d !== 1'b0 || bus.count !== '0) begin
      failCount++;
      $display("[TB] FAIL fill_drain got valid=%b count=%0d want 0 0", bus.valid_d, bus.count);
    end
  endtask

  task automatic test_flush();
    logic took;
    setIn(1'b1, 32'h3000, 1'b1, 1'b0); clockEdge(took);
    setIn(1'b1, 32'h3004, 1'b1, 1'b0); clockEdge(took);
    setIn(1'b1, 32'h3008, 1'b1, 1'b1); clockEdge(took);
    setIn(1'b0, 32'h0, 1'b0, 1'b0);
    assertCount++;
    if (bus.count !== '0 || bus.valid_d !== 1'b0 || bus.instr_d !== 32'h0 || bus.stop_f !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL flush_clear got count=%0d valid=%b instr=%h stop=%b want 0 0 0 0",
               bus.count, bus.valid_d, bus.instr_d, bus.stop_f);
    end
    setIn(1'b1, 32'h3100, 1'b0, 1'b0);
    clockEdge(took);
    setIn(1'b0, 32'h0, 1'b0, 1'b0);
`ifdef FD_BYPASS_EN
    assertCount++;
    if (bus.valid_d !== 1'b0 || bus.count !== '0) begin
      failCount++;
      $display("[TB] FAIL flush_refill got valid=%b count=%0d want 0 0", bus.valid_d, bus.count);
    end
`else
    assertCount++;
    if (bus.pc_d !== 32'h3100 || bus.valid_d !== 1'b1 || bus.count !== 2'd1) begin
      failCount++;
      $display("[TB] FAIL flush_refill got pc=%h valid=%b count=%0d want 3100 1 1",
               bus.pc_d, bus.valid_d, bus.count);
    end
`endif
    clockEdge(took);
  endtask

  task automatic test_wrap();
    logic took;
    logic [31:0] nextPc = 32'h4000;
    logic [13:0] stallPat = 14'b00_1011_0001_1010;
    int accepted = 0;
    for (int i = 0; i < 14; i++) begin
      setIn(1'b1, nextPc, stallPat[i], 1'b0);
      assertCount++;
      if (bus.valid_d !== expValid() || bus.pc_d !== expPc() || bus.instr_d !== expInstr()) begin
        failCount++;
        $display("[TB] FAIL wrap_head cycle %0d got valid=%b pc=%h instr=%h want %b %h %h",
                 i, bus.valid_d, bus.pc_d, bus.instr_d, expValid(), expPc(), expInstr());
      end
      assertCount++;
      if (bus.count !== expCount() || bus.stop_f !== expStop()) begin
        failCount++;
        $display("[TB] FAIL wrap_ctrl cycle %0d got count=%0d stop=%b want %0d %b",
                 i, bus.count, bus.stop_f, expCount(), expStop());
      end
      clockEdge(took);
      if (took) begin
        nextPc = nextPc + 32'd4;
        accepted++;
      end
    end
    for (int i = 0; i < DEPTH + 2 && sb.size() > 0; i++) begin
      setIn(1'b0, 32'h0, 1'b0, 1'b0);
      assertCount++;
      if (bus.pc_d !== sb[0]) begin
        failCount++;
        $display("[TB] FAIL wrap_drain got pc=%h want %h", bus.pc_d, sb[0]);
      end
      clockEdge(took);
    end
    assertCount++;
    if (sb.size() != 0 || bus.valid_d !== 1'b0 || accepted < 2 * DEPTH + 1) begin
      failCount++;
      $display("[TB] FAIL wrap_end got left=%0d valid=%b accepted=%0d want 0 0 >=%0d",
               sb.size(), bus.valid_d, accepted, 2 * DEPTH + 1);
    end
  endtask

  task automatic test_bypass();
    logic took;
    setIn(1'b1, 32'h3000, 1'b0, 1'b0);
`ifdef FD_BYPASS_EN
    assertCount++;
    if (bus.valid_d !== 1'b1 || bus.pc_d !== 32'h3000 || bus.count !== '0) begin
      failCount++;
      $display("[TB] FAIL bypass_same got valid=%b pc=%h count=%0d want 1 3000 0",
               bus.valid_d, bus.pc_d, bus.count);
    end
    clockEdge(took);
    setIn(1'b0, 32'h0, 1'b0, 1'b0);
    assertCount++;
    if (bus.valid_d !== 1'b0 || bus.count !== '0) begin
      failCount++;
      $display("[TB] FAIL bypass_after got valid=%b count=%0d want 0 0", bus.valid_d, bus.count);
    end
`else
    assertCount++;
    if (bus.valid_d !== 1'b0 || bus.count !== '0) begin
      failCount++;
      $display("[TB] FAIL latency_same got valid=%b count=%0d want 0 0", bus.valid_d, bus.count);
    end
    clockEdge(took);
    setIn(1'b0, 32'h0, 1'b0, 1'b0);
    assertCount++;
    if (bus.valid_d !== 1'b1 || bus.pc_d !== 32'h3000 || bus.count !== 2'd1) begin
      failCount++;
      $display("[TB] FAIL latency_next got valid=%b pc=%h count=%0d want 1 3000 1",
               bus.valid_d, bus.pc_d, bus.count);
    end
    clockEdge(took);
    assertCount++;
    if (bus.count !== '0 || bus.valid_d !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL latency_drain got count=%0d valid=%b want 0 0", bus.count, bus.valid_d);
    end
`endif
    clockEdge(took);
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_wrap();
    test_bypass();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
